led_blink_code: RTL and testbench

Drives a human-visible LED with a repeating blink code that shows a small status value, such as a PLL lock state or error class. A code value N gives N equal blinks, then a long dark gap, then the sequence repeats. This is the transmit-side counterpart to the transition-stretching activity indicator. Instantiated at the top level next to the activity LEDs, one instance per status LED.

---
 rtl/led_blink_code_pkg.sv | 19 +
 rtl/led_blink_code_unit_timer.sv | 29 ++
 rtl/led_blink_code.sv | 89 ++++++++
 tb/tb_led_blink_code.sv | 136 +++++++++++++
 4 files changed

// File: rtl/led_blink_code_pkg.sv
// Shared state encoding for LED blink-code drivers.
// Debug probes and other LED drivers decode these values the same way.
package led_blink_code_pkg;

  localparam int STATE_W = 2;

  localparam logic [STATE_W-1:0] ENC_LOAD = 2'd0;
  localparam logic [STATE_W-1:0] ENC_ON   = 2'd1;
  localparam logic [STATE_W-1:0] ENC_OFF  = 2'd2;
  localparam logic [STATE_W-1:0] ENC_GAP  = 2'd3;

  typedef enum logic [STATE_W-1:0] {
    S_LOAD = ENC_LOAD,
    S_ON   = ENC_ON,
    S_OFF  = ENC_OFF,
    S_GAP  = ENC_GAP
  } blink_state_e;

endpackage

// File: rtl/led_blink_code_unit_timer.sv
// Free-running divide-by-UNIT_CYCLES counter with synchronous clear.
// The terminal-count pulse is high for the last cycle of every unit.
module led_blink_code_unit_timer #(
  parameter int UNIT_CYCLES = 8388608
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tc
);

  localparam int CNT_W = $clog2(UNIT_CYCLES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(UNIT_CYCLES - 1);

  logic [CNT_W-1:0] unit_cnt;

  assign tc = (unit_cnt == LAST);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      unit_cnt <= '0;
    end else if (tc) begin
      unit_cnt <= '0;
    end else begin
      unit_cnt <= unit_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/led_blink_code.sv
// Blink-code LED driver: N equal blinks, a long dark gap, repeat.
// The code is latched once per frame so blink counts are never truncated or merged.
module led_blink_code
  import led_blink_code_pkg::*;
#(
  parameter int CODE_W      = 4,
  parameter int UNIT_CYCLES = 8388608,
  parameter int GAP_UNITS   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CODE_W-1:0] code,
  input  logic              force_on,
  output logic              led,
  output logic              frame_start
);

  localparam int GAP_W = $clog2(GAP_UNITS + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_UNITS - 1);

  blink_state_e      state;
  blink_state_e      state_next;
  logic [CODE_W-1:0] code_l;
  logic [CODE_W-1:0] remaining;
  logic [GAP_W-1:0]  gap_cnt;
  logic              unit_tc;
  logic              timer_clear;

  led_blink_code_unit_timer #(
    .UNIT_CYCLES(UNIT_CYCLES)
  ) u_unit_timer (
    .clk  (clk),
    .reset(reset),
    .clear(timer_clear),
    .tc   (unit_tc)
  );

  // The timer restarts at LOAD so the first ON or GAP unit is a full unit.
  always_comb begin
    state_next  = state;
    timer_clear = 1'b0;
    case (state)
      S_LOAD: begin
        timer_clear = 1'b1;
        state_next  = (code == '0) ? S_GAP : S_ON;
      end
      S_ON: begin
        if (unit_tc) state_next = S_OFF;
      end
      S_OFF: begin
        if (unit_tc) state_next = (remaining == '0 || code_l == '0) ? S_GAP : S_ON;
      end
      S_GAP: begin
        if (unit_tc && gap_cnt == GAP_LAST) state_next = S_LOAD;
      end
      default: state_next = S_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_LOAD;
      code_l      <= '0;
      remaining   <= '0;
      gap_cnt     <= '0;
      led         <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      state       <= state_next;
      led         <= (state == S_ON) || force_on;
      frame_start <= (state == S_LOAD);
      case (state)
        S_LOAD: begin
          code_l    <= code;
          remaining <= code;
          gap_cnt   <= '0;
        end
        S_ON: begin
          if (unit_tc && remaining != '0) remaining <= remaining - 1'b1;
        end
        S_GAP: begin
          if (unit_tc) gap_cnt <= (gap_cnt == GAP_LAST) ? '0 : gap_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_led_blink_code.sv
// Scoreboard bench for led_blink_code: a frame-position reference model
// predicts led/frame_start per cycle; a monitor compares on every falling edge.
module tb_led_blink_code;

  localparam int CODE_W = 4;
  localparam int UNIT   = 4;
  localparam int GAP    = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic [CODE_W-1:0] code;
  logic              force_on;
  logic              led;
  logic              frame_start;

  typedef struct packed {
    logic led;
    logic fs;
  } exp_t;

  exp_t expq[$];
  int   tests = 0;
  int   fails = 0;
  int   cycle = 0;

  bit running = 1'b0;
  int pos = 0;
  int len = 0;
  int n   = 0;

  always #5 clk = ~clk;

  led_blink_code #(
    .CODE_W     (CODE_W),
    .UNIT_CYCLES(UNIT),
    .GAP_UNITS  (GAP)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .code       (code),
    .force_on   (force_on),
    .led        (led),
    .frame_start(frame_start)
  );

  // pos is the index of the output cycle within the current frame; pos 0 is the frame_start cycle.
  task automatic applyStimulus(input bit r, input int c, input bit f);
    exp_t e;
    reset    = r;
    code     = CODE_W'(c);
    force_on = f;
    if (r) begin
      running = 1'b0;
      e.led   = 1'b0;
      e.fs    = 1'b0;
    end else begin
      if (!running || pos == len - 1) begin
        n       = c;
        len     = 1 + 2 * n * UNIT + GAP * UNIT;
        pos     = 0;
        running = 1'b1;
      end else begin
        pos++;
      end
      e.fs  = (pos == 0);
      e.led = f || (pos >= 1 && (pos - 1) / UNIT < 2 * n && ((pos - 1) / UNIT) % 2 == 0);
    end
    expq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic runCycles(input int count, input bit r, input int c, input bit f);
    for (int i = 0; i < count; i++) applyStimulus(r, c, f);
  endtask

  task automatic checkOutput();
    exp_t e;
    e = expq.pop_front();
    tests++;
    if (led !== e.led || frame_start !== e.fs) begin
      fails++;
      $display("[TB] FAIL cycle %0d led/frame_start: got %b/%b expected %b/%b",
               cycle, led, frame_start, e.led, e.fs);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      cycle++;
      if (expq.size() > 0) checkOutput();
    end
  end

  initial begin
    int c;
    bit f;
    bit r;
    runCycles(3, 1'b1, 3, 1'b0);
    // Steady code=3, then code=0.
    runCycles(80, 1'b0, 3, 1'b0);
    runCycles(30, 1'b0, 0, 1'b0);
    // Mid-frame code change 3 -> 1 must not affect the running frame.
    runCycles(4, 1'b1, 3, 1'b0);
    runCycles(8, 1'b0, 3, 1'b0);
    runCycles(60, 1'b0, 1, 1'b0);
    // Full-scale code exercises the remaining-count boundary.
    runCycles(280, 1'b0, 15, 1'b0);
    // Reset for 3 cycles while the LED is on.
    runCycles(2, 1'b1, 2, 1'b0);
    runCycles(3, 1'b0, 2, 1'b0);
    runCycles(3, 1'b1, 2, 1'b0);
    runCycles(20, 1'b0, 2, 1'b0);
    // Lamp test during the dark gap.
    runCycles(5, 1'b0, 2, 1'b1);
    runCycles(40, 1'b0, 2, 1'b0);
    c = 5;
    f = 1'b0;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 59) == 0) c = $urandom_range(0, 15);
      if ($urandom_range(0, 24) == 0) f = ~f;
      r = ($urandom_range(0, 399) == 0);
      applyStimulus(r, c, f);
    end
    repeat (3) @(negedge clk);
    if (expq.size() != 0) begin
      tests++;
      fails++;
      $display("[TB] FAIL scoreboard drain: got %0d pending expected 0", expq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
